// File: rtl/montgomery_mux_sequencer.sv
// Radix-4 Montgomery multiplier sequencer: walks operand A one digit per iteration
// and drives the multiple-mux select. Optional macro: SKIP_ZERO_DIGIT_EN.
module montgomery_mux_sequencer #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       m_low2,
  input  logic [1:0]       c_low2,
  output logic [2:0]       select,
  output logic             acc_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = $clog2(WIDTH / 2);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, ADD_B, ADD_M, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       m_r;
  logic             err_r;

  logic             skip_first;
  logic             skip_next;
  logic [1:0]       cm;
  logic [1:0]       q;

  // Zero digits bypass ADD_B only when the skip feature is compiled in.
  always_comb begin
`ifdef SKIP_ZERO_DIGIT_EN
    skip_first = (in_a[1:0] == 2'b00);
    skip_next  = (a_reg[3:2] == 2'b00);
`else
    skip_first = 1'b0;
    skip_next  = 1'b0;
`endif
  end

  // q cancels the low two accumulator bits: q = -(c * m) mod 4.
  always_comb begin
    cm = c_low2 * m_r;
    q  = 2'b00 - cm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_reg <= '0;
      cnt   <= '0;
      m_r   <= 2'b00;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= in_a;
            m_r   <= m_low2;
            cnt   <= '0;
            if (!m_low2[0]) begin
              err_r <= 1'b1;
              state <= DONE;
            end else begin
              err_r <= 1'b0;
              state <= skip_first ? ADD_M : ADD_B;
            end
          end
        end
        ADD_B: state <= ADD_M;
        ADD_M: begin
          a_reg <= {2'b00, a_reg[WIDTH-1:2]};
          // The counter parks on the last digit instead of wrapping.
          if (cnt == LAST_DIGIT) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= skip_next ? ADD_M : ADD_B;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    select   = 3'b000;
    acc_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      ADD_B: begin
        select = (a_reg[1:0] == 2'b00) ? 3'b000 : 3'(a_reg[1:0]) + 3'd3;
        acc_en = 1'b1;
        busy   = 1'b1;
      end
      ADD_M: begin
        select   = {1'b0, q};
        acc_en   = 1'b1;
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        err  = err_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_montgomery_mux_sequencer.sv
// Self-checking bench for montgomery_mux_sequencer (WIDTH=8) against a per-cycle
// expected-output list built from the digit/iteration rules.
module tb_montgomery_mux_sequencer;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] in_a;
  logic [1:0]       m_low2;
  logic [1:0]       c_low2;
  logic [2:0]       select;
  logic             acc_en;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic             err;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] outs;
    logic [1:0] c;
  } step_t;

  montgomery_mux_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_a(in_a), .m_low2(m_low2),
    .c_low2(c_low2), .select(select), .acc_en(acc_en), .shift_en(shift_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed();
    return {select, acc_en, shift_en, busy, done, err};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b (sel,acc,sh,busy,done,err)", tag, obs, exp);
    end
  endtask

  function automatic bit skipping();
`ifdef SKIP_ZERO_DIGIT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Builds the expected cycle list for one operation, then drives it and checks each cycle.
  // c_seq supplies c_low2 for ADD_M iteration i in bits [2i+1:2i] when use_seq is set.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [1:0] m,
                               input int pulse_at, input bit use_seq, input logic [7:0] c_seq);
    step_t exp_q[$];
    step_t s;
    int    d, c, qv, acc_seen, acc_exp;
    acc_exp = 0;
    if (m[0] == 1'b0) begin
      s.outs = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      s.c    = 2'($urandom_range(0, 3));
      exp_q.push_back(s);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        d = (int'(a) >> (2 * i)) & 3;
        if (!(skipping() && d == 0)) begin
          s.outs = {(d == 0) ? 3'd0 : 3'(d + 3), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
          s.c    = 2'($urandom_range(0, 3));
          exp_q.push_back(s);
          acc_exp++;
        end
        c  = use_seq ? ((int'(c_seq) >> (2 * i)) & 3) : int'($urandom_range(0, 3));
        qv = (4 - ((c * int'(m)) % 4)) % 4;
        s.outs = {3'(qv), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        s.c    = 2'(c);
        exp_q.push_back(s);
        acc_exp++;
      end
      s.outs = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      s.c    = 2'b00;
      exp_q.push_back(s);
    end

    @(negedge clk);
    start  = 1'b1;
    in_a   = a;
    m_low2 = m;
    @(posedge clk);
    #1;
    start  = 1'b0;
    in_a   = WIDTH'($urandom);
    m_low2 = 2'($urandom_range(0, 3));
    acc_seen = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      c_low2 = exp_q[k].c;
      start  = (k == pulse_at);
      #1;
      checkOutput($sformatf("op a=%h m=%0d cyc%0d", a, m, k + 1), observed(), exp_q[k].outs);
      if (acc_en) acc_seen++;
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("back to idle", observed(), 8'd0);
    if (pulse_at >= 0)
      checkOutput("acc_en pulse count", 8'(acc_seen), 8'(acc_exp));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    in_a   = '0;
    m_low2 = 2'b00;
    c_low2 = 2'b00;
    #1;
    checkOutput("reset outputs", observed(), 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed: digits 2,3,0,0 with c=10 then 01 give selects 101,010,110,011.
    applyStimulus(8'h0E, 2'b01, -1, 1'b1, 8'b0000_0110);
    // c sweep 00/01/10/11 with both odd m values.
    applyStimulus(8'hFF, 2'b11, -1, 1'b1, 8'b1110_0100);
    applyStimulus(8'hFF, 2'b01, -1, 1'b1, 8'b1110_0100);
    // Even modulus: immediate done with err.
    applyStimulus(8'h5A, 2'b10, -1, 1'b0, 8'h00);
    // Second start during ADD_B must be ignored.
    applyStimulus(8'h9B, 2'b01, 0, 1'b0, 8'h00);
    // Skip-pattern operand.
    applyStimulus(8'h0C, 2'b11, -1, 1'b0, 8'h00);

    // Abort mid-operation with reset; no done may follow.
    @(negedge clk);
    start  = 1'b1;
    in_a   = 8'hE6;
    m_low2 = 2'b01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset mid-op", observed(), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("idle after abort %0d", k), observed(), 8'd0);
    end
    applyStimulus(8'hE6, 2'b01, -1, 1'b0, 8'h00);

    for (int r = 0; r < 12; r++)
      applyStimulus(WIDTH'($urandom), 2'($urandom_range(0, 3)), -1, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
